// File: rtl/fp_add_sequencer.sv
// Purpose: arbitrates two FP add/sub requesters, orders/aligns operands and sequences the shared compute datapath.
// Latency: response valid 3+d cycles after accept (d = exponent difference), 2 cycles on the bypass path.
// Backpressure: one transaction in flight; reqN_ready held low from accept until the response handshake completes.
module fp_add_sequencer #(
   parameter int FAIR         = 1,
   parameter int BYPASS_LIMIT = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req0_sub,
   input  logic        req1_sub,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   input  logic        rsp0_ready,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_result,
   output logic        dp_s1,
   output logic        dp_s2,
   output logic [23:0] dp_m1,
   output logic [23:0] dp_m2,
   output logic [7:0]  dp_e1,
   input  logic [22:0] dp_m3,
   input  logic [7:0]  dp_e3,
   output logic        busy
);

   localparam logic       RR_EN   = (FAIR != 0);
   localparam logic [7:0] BYP_LIM = 8'(BYPASS_LIMIT);

   typedef enum logic [2:0] {IDLE, LOAD, ALIGN, EXEC, RESP} state_t;

   state_t      state;
   logic        arb_en;     // low right after reset and while a transaction is in flight
   logic        rr_q;       // 1 = req1 wins a tie next time
   logic        owner_q;
   logic        sub_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [7:0]  cnt_q;
   logic        w_s1;
   logic        w_s2;
   logic [23:0] w_m1;
   logic [23:0] w_m2;
   logic [7:0]  w_e1;

   logic        gnt0;
   logic        gnt1;
   logic [7:0]  ea;
   logic [7:0]  eb;
   logic [7:0]  e1;
   logic [7:0]  e2;
   logic [7:0]  d;
   logic        za;
   logic        zb;
   logic        sa;
   logic        sb;
   logic        a_ge;
   logic        s1;
   logic        s2;
   logic [23:0] ma;
   logic [23:0] mb;
   logic [23:0] m1;
   logic [23:0] m2;
   logic        byp;
   logic [31:0] byp_res;

   // Pick this cycle's winner: round-robin on a tie, or req0 always first when fairness is off.
   always_comb begin
      gnt1 = 1'b0;
      if (RR_EN) begin
         gnt1 = req1_valid & (~req0_valid | rr_q);
      end else begin
         gnt1 = req1_valid & ~req0_valid;
      end
      gnt0 = req0_valid & ~gnt1;
   end

   assign req0_ready = arb_en & gnt0;
   assign req1_ready = arb_en & gnt1;

   // Unpack the captured operands, flush zero exponents and order by magnitude.
   always_comb begin
      ea   = a_q[30:23];
      eb   = b_q[30:23];
      za   = (ea == 8'd0);
      zb   = (eb == 8'd0);
      sa   = a_q[31];
      sb   = b_q[31] ^ sub_q;
      ma   = za ? 24'd0 : {1'b1, a_q[22:0]};
      mb   = zb ? 24'd0 : {1'b1, b_q[22:0]};
      // Exponent sits above the fraction, so the raw magnitude bits order correctly.
      a_ge = (a_q[30:0] >= b_q[30:0]);
      s1   = a_ge ? sa : sb;
      s2   = a_ge ? sb : sa;
      e1   = a_ge ? ea : eb;
      e2   = a_ge ? eb : ea;
      m1   = a_ge ? ma : mb;
      m2   = a_ge ? mb : ma;
      d    = e1 - e2;
   end

   // Short-circuit cases that never need the datapath, checked in priority order.
   always_comb begin
      byp     = 1'b1;
      byp_res = 32'd0;
      if (za && zb) begin
         byp_res = 32'd0;
      end else if (za) begin
         byp_res = {sb, b_q[30:0]};
      end else if (zb) begin
         byp_res = a_q;
      end else if ((a_q[30:0] == b_q[30:0]) && (sa != sb)) begin
         byp_res = 32'd0;
      end else if ((e1 == 8'hFF) || (d > BYP_LIM)) begin
         byp_res = {s1, e1, m1[22:0]};
      end else begin
         byp = 1'b0;
      end
   end

   // Transaction sequencer: accept, load/order, align one bit per cycle, execute, respond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         arb_en     <= 1'b0;
         rr_q       <= 1'b0;
         owner_q    <= 1'b0;
         sub_q      <= 1'b0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         cnt_q      <= 8'd0;
         w_s1       <= 1'b0;
         w_s2       <= 1'b0;
         w_m1       <= 24'd0;
         w_m2       <= 24'd0;
         w_e1       <= 8'd0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_result <= 32'd0;
         dp_s1      <= 1'b0;
         dp_s2      <= 1'b0;
         dp_m1      <= 24'd0;
         dp_m2      <= 24'd0;
         dp_e1      <= 8'd0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               arb_en <= 1'b1;
               if (req0_ready || req1_ready) begin
                  a_q     <= req1_ready ? req1_a : req0_a;
                  b_q     <= req1_ready ? req1_b : req0_b;
                  sub_q   <= req1_ready ? req1_sub : req0_sub;
                  owner_q <= req1_ready;
                  busy    <= 1'b1;
                  arb_en  <= 1'b0;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               w_s1  <= s1;
               w_s2  <= s2;
               w_m1  <= m1;
               w_m2  <= m2;
               w_e1  <= e1;
               cnt_q <= d;
               if (byp) begin
                  rsp_result <= byp_res;
                  rsp0_valid <= ~owner_q;
                  rsp1_valid <= owner_q;
                  state      <= RESP;
               end else if (d == 8'd0) begin
                  dp_s1 <= s1;
                  dp_s2 <= s2;
                  dp_m1 <= m1;
                  dp_m2 <= m2;
                  dp_e1 <= e1;
                  state <= EXEC;
               end else begin
                  state <= ALIGN;
               end
            end
            ALIGN: begin
               w_m2  <= w_m2 >> 1;
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  dp_s1 <= w_s1;
                  dp_s2 <= w_s2;
                  dp_m1 <= w_m1;
                  dp_m2 <= w_m2 >> 1;
                  dp_e1 <= w_e1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= {dp_s1, dp_e3, dp_m3};
               rsp0_valid <= ~owner_q;
               rsp1_valid <= owner_q;
               state      <= RESP;
            end
            RESP: begin
               if (owner_q ? rsp1_ready : rsp0_ready) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  busy       <= 1'b0;
                  rr_q       <= ~owner_q;
                  arb_en     <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: random and directed transactions against a behavioural model.
// Latency is measured in clock edges from request acceptance to the first sampled response valid.
// A second instance with fixed priority shares the stimulus to compare arbitration policies.
module tb_fp_add_sequencer;

   localparam longint TWO24 = 64'sd16777216;
   localparam longint TWO23 = 64'sd8388608;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_sub, req1_sub;
   logic        rsp0_ready, rsp1_ready;

   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
   logic [31:0] rsp_result;
   logic        dp_s1, dp_s2;
   logic [23:0] dp_m1, dp_m2;
   logic [7:0]  dp_e1, dp_e3;
   logic [22:0] dp_m3;

   logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_busy;
   logic [31:0] f_rsp_result;
   logic        f_dp_s1, f_dp_s2;
   logic [23:0] f_dp_m1, f_dp_m2;
   logic [7:0]  f_dp_e1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_add_sequencer #(.FAIR(1), .BYPASS_LIMIT(24)) u0 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_sub(req0_sub), .req1_sub(req1_sub),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result),
      .dp_s1(dp_s1), .dp_s2(dp_s2), .dp_m1(dp_m1), .dp_m2(dp_m2), .dp_e1(dp_e1),
      .dp_m3(dp_m3), .dp_e3(dp_e3), .busy(busy)
   );

   fp_add_sequencer #(.FAIR(0), .BYPASS_LIMIT(24)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(f_req0_ready), .req1_ready(f_req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_sub(req0_sub), .req1_sub(req1_sub),
      .rsp0_valid(f_rsp0_valid), .rsp1_valid(f_rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_result(f_rsp_result),
      .dp_s1(f_dp_s1), .dp_s2(f_dp_s2), .dp_m1(f_dp_m1), .dp_m2(f_dp_m2), .dp_e1(f_dp_e1),
      .dp_m3(23'd0), .dp_e3(8'd0), .busy(f_busy)
   );

   // Normalizing adder: exact sum/difference of hidden-bit mantissas, truncating renormalization.
   function automatic logic [30:0] dp_norm(input logic s1, input logic s2,
                                          input logic [23:0] m1, input logic [23:0] m2,
                                          input logic [7:0] e1);
      longint     r;
      int         e;
      logic [63:0] rv;
      e = int'(e1);
      if (s1 == s2) r = longint'(m1) + longint'(m2);
      else          r = longint'(m1) - longint'(m2);
      if (r <= 0) return 31'd0;
      while (r >= TWO24) begin r = r / 2; e++; end
      while (r < TWO23)  begin r = r * 2; e--; end
      rv = r;
      return {e[7:0], rv[22:0]};
   endfunction

   // The external compute block driven by the sequencer.
   always_comb {dp_e3, dp_m3} = dp_norm(dp_s1, dp_s2, dp_m1, dp_m2, dp_e1);

   // Expected result and accept-to-valid latency of one operation.
   function automatic logic [31:0] ref_fp(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub, output int lat);
      logic       sa, sb, s1, s2;
      int         ea, eb, e1, e2, d;
      logic [23:0] m1, m2;
      sa  = a[31];
      sb  = b[31] ^ sub;
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      lat = 2;
      if (ea == 0 && eb == 0) return 32'd0;
      if (ea == 0) return {sb, b[30:0]};
      if (eb == 0) return a;
      if (a[30:0] == b[30:0] && sa != sb) return 32'd0;
      if (ea > eb || (ea == eb && a[22:0] >= b[22:0])) begin
         s1 = sa; e1 = ea; m1 = {1'b1, a[22:0]};
         s2 = sb; e2 = eb; m2 = {1'b1, b[22:0]};
      end else begin
         s1 = sb; e1 = eb; m1 = {1'b1, b[22:0]};
         s2 = sa; e2 = ea; m2 = {1'b1, a[22:0]};
      end
      d = e1 - e2;
      if (e1 == 255 || d > 24) return {s1, 8'(e1), m1[22:0]};
      lat = 3 + d;
      m2  = 24'(m2 / (24'd1 << d));
      return {s1, dp_norm(s1, s2, m1, m2, 8'(e1))};
   endfunction

   function automatic logic [31:0] rand_op(input int lo, input int hi);
      logic [31:0] r;
      r        = $urandom;
      r[30:23] = 8'($urandom_range(hi, lo));
      return r;
   endfunction

   // Issue one request on a port and wait for its response; rsp ready must already be high.
   task automatic run_txn(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, output logic [31:0] res, output int lat, output int rport);
      int n;
      res = 32'd0; lat = -1; rport = -1;
      @(negedge clk);
      if (port == 0) begin
         req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
      end
      #1;
      n = 0;
      while (!((port == 0) ? req0_ready : req1_ready) && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 50) begin
         req0_valid = 1'b0; req1_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (rsp0_valid || rsp1_valid) break;
      end
      if (rsp0_valid || rsp1_valid) begin
         lat   = n;
         res   = rsp_result;
         rport = rsp1_valid ? 1 : 0;
         @(posedge clk); #1;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_sub = 1'b0;
      req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_sub = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #3;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, dp_s1, dp_s2} !== 7'd0) begin
         errors++;
         $display("FAIL reset_ctrl got %b expected 0000000",
                  {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, dp_s1, dp_s2});
      end
      checks++;
      if (rsp_result !== 32'd0) begin
         errors++; $display("FAIL reset_result got %h expected 00000000", rsp_result);
      end
      checks++;
      if ({dp_m1, dp_m2, dp_e1} !== 56'd0) begin
         errors++; $display("FAIL reset_dp got %h expected 0", {dp_m1, dp_m2, dp_e1});
      end
      @(negedge clk); @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      int          pv[5] = '{0, 1, 0, 0, 1};
      logic [31:0] av[5] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h00000000, 32'h4E800000};
      logic [31:0] bv[5] = '{32'h3F800000, 32'h3E800000, 32'h40000000, 32'hC0400000, 32'h3F800000};
      logic        sv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] rv[5] = '{32'h40000000, 32'h3FE00000, 32'h00000000, 32'hC0400000, 32'h4E800000};
      int          lv[5] = '{3, 5, 2, 2, 2};
      logic [31:0] res;
      int          lat, rport;
      for (int i = 0; i < 5; i++) begin
         run_txn(pv[i], av[i], bv[i], sv[i], res, lat, rport);
         checks++;
         if (res !== rv[i]) begin
            errors++; $display("FAIL dir_result[%0d] got %h expected %h", i, res, rv[i]);
         end
         checks++;
         if (lat != lv[i]) begin
            errors++; $display("FAIL dir_latency[%0d] got %0d expected %0d", i, lat, lv[i]);
         end
         checks++;
         if (rport != pv[i]) begin
            errors++; $display("FAIL dir_port[%0d] got %0d expected %0d", i, rport, pv[i]);
         end
         if (i == 1) begin
            checks++;
            if ({dp_s1, dp_s2, dp_m1, dp_m2, dp_e1} !== {1'b0, 1'b0, 24'hC00000, 24'h200000, 8'd127}) begin
               errors++;
               $display("FAIL dir_dp_held got m1=%h m2=%h e1=%0d expected m1=c00000 m2=200000 e1=127",
                        dp_m1, dp_m2, dp_e1);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, res, exp_res;
      logic        sub;
      int          port, lat, rport, exp_lat, mode;
      for (int i = 0; i < 30; i++) begin
         port = int'($urandom_range(1, 0));
         sub  = 1'($urandom);
         mode = int'($urandom_range(9, 0));
         if (mode == 0)      a = rand_op(0, 0);
         else if (mode == 1) a = rand_op(255, 255);
         else                a = rand_op(110, 140);
         mode = int'($urandom_range(7, 0));
         if (mode == 0)      b = {1'($urandom), a[30:0]};
         else if (mode == 1) b = rand_op(0, 0);
         else                b = rand_op(95, 140);
         exp_res = ref_fp(a, b, sub, exp_lat);
         run_txn(port, a, b, sub, res, lat, rport);
         checks++;
         if (res !== exp_res) begin
            errors++; $display("FAIL rnd_result a=%h b=%h sub=%0d got %h expected %h", a, b, sub, res, exp_res);
         end
         checks++;
         if (lat != exp_lat) begin
            errors++; $display("FAIL rnd_latency a=%h b=%h got %0d expected %0d", a, b, lat, exp_lat);
         end
         checks++;
         if (rport != port) begin
            errors++; $display("FAIL rnd_port got %0d expected %0d", rport, port);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      int          n;
      rsp0_ready = 1'b0;
      @(negedge clk);
      req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_sub = 1'b0; req0_valid = 1'b1;
      #1;
      n = 0;
      while (!req0_ready && n < 50) begin @(negedge clk); #1; n++; end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_sub = 1'b0; req1_valid = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (rsp0_valid) break;
      end
      held = rsp_result;
      checks++;
      if (held !== 32'h40000000 || rsp0_valid !== 1'b1) begin
         errors++; $display("FAIL bp_first got valid=%b result=%h expected valid=1 result=40000000", rsp0_valid, held);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, busy} !== 5'b10001) begin
            errors++;
            $display("FAIL bp_hold[%0d] got %b expected 10001", c, {rsp0_valid, rsp1_valid, req0_ready, req1_ready, busy});
         end
         checks++;
         if (rsp_result !== held) begin
            errors++; $display("FAIL bp_result[%0d] got %h expected %h", c, rsp_result, held);
         end
      end
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({rsp0_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL bp_release got %b expected 00", {rsp0_valid, busy});
      end
   endtask

   task automatic test_fairness();
      int g_rr[$];
      int g_fx[$];
      apply_reset();
      req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_sub = 1'b0;
      req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_sub = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk); #1;
         if (req0_ready)   g_rr.push_back(0);
         if (req1_ready)   g_rr.push_back(1);
         if (f_req0_ready) g_fx.push_back(0);
         if (f_req1_ready) g_fx.push_back(1);
         if (g_rr.size() >= 4 && g_fx.size() >= 4) break;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++;
      if (g_rr.size() < 4 || g_fx.size() < 4) begin
         errors++; $display("FAIL fair_timeout got %0d/%0d grants expected 4/4", g_rr.size(), g_fx.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (g_rr[i] != (i % 2)) begin
               errors++; $display("FAIL fair_rr[%0d] got %0d expected %0d", i, g_rr[i], i % 2);
            end
            checks++;
            if (g_fx[i] != 0) begin
               errors++; $display("FAIL fair_fixed[%0d] got %0d expected 0", i, g_fx[i]);
            end
         end
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset_abort();
      logic [31:0] res;
      int          lat, rport, n;
      bit          seen;
      run_txn(0, 32'h3F800000, 32'h3F800000, 1'b0, res, lat, rport);
      @(negedge clk);
      req1_a = 32'h3FC00000; req1_b = 32'h3E800000; req1_sub = 1'b0; req1_valid = 1'b1;
      #1;
      n = 0;
      while (!req1_ready && n < 50) begin @(negedge clk); #1; n++; end
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, dp_s1, dp_s2} !== 7'd0) begin
         errors++;
         $display("FAIL abort_ctrl got %b expected 0000000",
                  {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, dp_s1, dp_s2});
      end
      checks++;
      if (rsp_result !== 32'd0) begin
         errors++; $display("FAIL abort_result got %h expected 00000000", rsp_result);
      end
      checks++;
      if ({dp_m1, dp_m2, dp_e1} !== 56'd0) begin
         errors++; $display("FAIL abort_dp got %h expected 0", {dp_m1, dp_m2, dp_e1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (rsp0_valid || rsp1_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL abort_no_rsp got response expected none");
      end
      req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_sub = 1'b0;
      req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_sub = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 50) begin @(negedge clk); #1; n++; end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL abort_next_grant got %b expected 10", {req0_ready, req1_ready});
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rsp0_valid || rsp1_valid) break;
      end
      checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_result !== 32'h40000000) begin
         errors++;
         $display("FAIL abort_next_rsp got %b/%h expected 10/40000000", {rsp0_valid, rsp1_valid}, rsp_result);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_fairness();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
